// File: rtl/maze_pkg.sv
// Shared maze geometry and cell encodings for the 8x8 maze memory.
// Sized so one cell code fits exactly in one memory word.
package maze_pkg;

    localparam int MAZE_ADDR_W = 6;
    localparam int MAZE_DATA_W = 2;

    typedef enum logic [MAZE_DATA_W-1:0] {
        CELL_WALL   = 2'b00,
        CELL_PATH   = 2'b01,
        CELL_PLAYER = 2'b10,
        CELL_GOAL   = 2'b11
    } cell_t;

endpackage

// File: rtl/maze_rr_pick.sv
// Two-way round-robin picker, purely combinational (0 cycles).
// A lone requester always wins; on a tie the port not granted last wins.
module maze_rr_pick (
    input  logic i_req_a,
    input  logic i_req_b,
    input  logic i_last_b,
    output logic o_pick_a,
    output logic o_pick_b
);

    assign o_pick_a = i_req_a & (~i_req_b | i_last_b);
    assign o_pick_b = i_req_b & (~i_req_a | ~i_last_b);

endmodule

// File: rtl/maze_mem_arbiter.sv
// Arbitrates game-logic (A) and display-refresh (B) ports onto one maze memory.
// Grant and command register 1 cycle after the decision; rvalid 1 cycle after grant; a bounded A lock stalls B.
module maze_mem_arbiter
    import maze_pkg::*;
#(
    parameter int ADDR_W   = MAZE_ADDR_W,
    parameter int DATA_W   = MAZE_DATA_W,
    parameter int LOCK_MAX = 8
) (
    input  logic              clk,
    input  logic              nst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic              a_lock,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              lock_err
);

    localparam logic [1:0] ST_RR       = 2'd0;
    localparam logic [1:0] ST_LOCKED_A = 2'd1;
    localparam logic [1:0] ST_BREAK    = 2'd2;
    localparam int         CNT_W       = $clog2(LOCK_MAX + 1);

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_lock_cnt;
    logic              r_lock_err;
    logic              r_last_b;
    logic              r_a_gnt;
    logic              r_b_gnt;
    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_a_rvalid;
    logic              r_b_rvalid;
    logic [DATA_W-1:0] r_a_rhold;
    logic [DATA_W-1:0] r_b_rhold;

    logic              w_a_elig;
    logic              w_b_elig;
    logic              w_pick_a;
    logic              w_pick_b;
    logic              w_gnt_a;
    logic              w_gnt_b;
    logic [1:0]        w_nxt_state;
    logic [CNT_W-1:0]  w_nxt_cnt;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic              w_set_err;

    // A port being granted this cycle still shows its old request; mask it so it is not served twice.
    assign w_a_elig  = a_req & ~r_a_gnt;
    assign w_b_elig  = b_req & ~r_b_gnt;
    assign w_cnt_inc = r_lock_cnt + CNT_W'(1);

    maze_rr_pick u_pick (
        .i_req_a  (w_a_elig),
        .i_req_b  (w_b_elig),
        .i_last_b (r_last_b),
        .o_pick_a (w_pick_a),
        .o_pick_b (w_pick_b)
    );

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_lock_cnt;
        w_gnt_a     = 1'b0;
        w_gnt_b     = 1'b0;
        w_set_err   = 1'b0;
        case (r_state)
            ST_RR: begin
                w_gnt_a = w_pick_a;
                w_gnt_b = w_pick_b;
                if (w_pick_a && a_lock) begin
                    w_nxt_state = ST_LOCKED_A;
                    w_nxt_cnt   = '0;
                end
            end
            ST_LOCKED_A: begin
                if (!a_lock) begin
                    w_nxt_state = ST_RR;
                    w_nxt_cnt   = '0;
                    w_gnt_a     = w_pick_a;
                    w_gnt_b     = w_pick_b;
                end else begin
                    w_gnt_a = w_a_elig;
                    if (b_req) begin
                        w_nxt_cnt = w_cnt_inc;
                        if (w_cnt_inc == CNT_W'(LOCK_MAX)) begin
                            w_nxt_state = ST_BREAK;
                            w_set_err   = 1'b1;
                        end
                    end
                end
            end
            ST_BREAK: begin
                // One slot for B, then the lock resumes with a fresh budget if A still holds it.
                w_gnt_b     = w_b_elig;
                w_nxt_cnt   = '0;
                w_nxt_state = a_lock ? ST_LOCKED_A : ST_RR;
            end
            default: begin
                w_nxt_state = ST_RR;
                w_nxt_cnt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nst) begin
        if (!nst) begin
            r_state     <= ST_RR;
            r_lock_cnt  <= '0;
            r_lock_err  <= 1'b0;
            r_last_b    <= 1'b1;
            r_a_gnt     <= 1'b0;
            r_b_gnt     <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_a_rvalid  <= 1'b0;
            r_b_rvalid  <= 1'b0;
            r_a_rhold   <= '0;
            r_b_rhold   <= '0;
        end else begin
            r_state    <= w_nxt_state;
            r_lock_cnt <= w_nxt_cnt;
            if (w_set_err) begin
                r_lock_err <= 1'b1;
            end
            r_a_gnt  <= w_gnt_a;
            r_b_gnt  <= w_gnt_b;
            r_mem_en <= w_gnt_a | w_gnt_b;
            r_mem_we <= w_gnt_a ? a_we : (w_gnt_b ? b_we : 1'b0);
            if (w_gnt_a) begin
                r_mem_addr  <= a_addr;
                r_mem_wdata <= a_wdata;
            end else if (w_gnt_b) begin
                r_mem_addr  <= b_addr;
                r_mem_wdata <= b_wdata;
            end
            if (w_gnt_a || w_gnt_b) begin
                r_last_b <= w_gnt_b;
            end
            r_a_rvalid <= r_a_gnt & ~r_mem_we;
            r_b_rvalid <= r_b_gnt & ~r_mem_we;
            if (r_a_rvalid) begin
                r_a_rhold <= mem_rdata;
            end
            if (r_b_rvalid) begin
                r_b_rhold <= mem_rdata;
            end
        end
    end

    assign a_gnt     = r_a_gnt;
    assign b_gnt     = r_b_gnt;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign lock_err  = r_lock_err;
    assign a_rvalid  = r_a_rvalid;
    assign b_rvalid  = r_b_rvalid;
    // Read data is forwarded straight from memory in the rvalid cycle, then held.
    assign a_rdata   = r_a_rvalid ? mem_rdata : r_a_rhold;
    assign b_rdata   = r_b_rvalid ? mem_rdata : r_b_rhold;

endmodule

// File: tb/tb_maze_mem_arbiter.sv
// Directed bench for maze_mem_arbiter with a synchronous memory model and read-data scoreboard.
module tb_maze_mem_arbiter;

    logic       clk = 1'b0;
    logic       nst;
    logic       a_req, a_we, a_lock, b_req, b_we;
    logic [5:0] a_addr, b_addr;
    logic [1:0] a_wdata, b_wdata;
    logic       a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [1:0] a_rdata, b_rdata;
    logic       mem_en, mem_we, lock_err;
    logic [5:0] mem_addr;
    logic [1:0] mem_wdata;
    logic [1:0] mem_rdata = 2'b00;

    int n_checks = 0;
    int n_errors = 0;

    logic [1:0] mem_arr [64];
    logic [1:0] exp_mem [64];
    bit         mem_loaded = 1'b0;
    logic [1:0] a_q [$];
    logic [1:0] b_q [$];
    bit         prev_a_rd = 1'b0;
    bit         prev_b_rd = 1'b0;

    maze_mem_arbiter dut (
        .clk(clk), .nst(nst),
        .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .lock_err(lock_err)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] init_val(input int i);
        logic [31:0] v;
        v = i;
        return (i == 9) ? 2'b10 : v[1:0];
    endfunction

    // Synchronous single-port memory: read data appears the cycle after the command.
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 64; i++) mem_arr[i] <= init_val(i);
            mem_loaded <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) mem_arr[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem_arr[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk(tag, {a_gnt, b_gnt, a_rvalid, b_rvalid, mem_en, mem_we, lock_err,
                  a_rdata, b_rdata, mem_addr, mem_wdata}, 32'd0);
    endtask

    // Protocol monitor and read-data scoreboard.
    always @(negedge clk) begin
        if (!nst) begin
            prev_a_rd = 1'b0;
            prev_b_rd = 1'b0;
        end else begin
            chk("gnt_exclusive", a_gnt & b_gnt, 0);
            chk("mem_en_vs_gnt", mem_en, a_gnt | b_gnt);
            chk("mem_we_idle", mem_we & ~mem_en, 0);
            chk("a_rvalid_timing", a_rvalid, prev_a_rd);
            chk("b_rvalid_timing", b_rvalid, prev_b_rd);
            if (a_rvalid) begin
                chk("a_q_nonempty", a_q.size() != 0, 1);
                if (a_q.size() != 0) chk("a_rdata_sb", a_rdata, a_q.pop_front());
            end
            if (b_rvalid) begin
                chk("b_q_nonempty", b_q.size() != 0, 1);
                if (b_q.size() != 0) chk("b_rdata_sb", b_rdata, b_q.pop_front());
            end
            prev_a_rd = a_gnt & ~mem_we;
            prev_b_rd = b_gnt & ~mem_we;
        end
    end

    task automatic issue(input bit pb, input bit we, input logic [5:0] addr,
                         input logic [1:0] wd, input string tag);
        bit got;
        if (!pb) begin a_req = 1; a_we = we; a_addr = addr; a_wdata = wd; end
        else     begin b_req = 1; b_we = we; b_addr = addr; b_wdata = wd; end
        if (we)       exp_mem[addr] = wd;
        else if (!pb) a_q.push_back(exp_mem[addr]);
        else          b_q.push_back(exp_mem[addr]);
        got = 0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (pb ? b_gnt : a_gnt) begin
                got = 1;
                chk({tag, "_addr"}, mem_addr, addr);
                chk({tag, "_we"}, mem_we, we);
                if (we) chk({tag, "_wdata"}, mem_wdata, wd);
            end
        end
        chk({tag, "_gnt"}, got, 1);
        @(posedge clk); #1;
        if (!pb) a_req = 0; else b_req = 0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 10 && (a_q.size() + b_q.size()) != 0; i++) @(negedge clk);
        #1;
        chk({tag, "_drain"}, a_q.size() + b_q.size(), 0);
    endtask

    task automatic wait_gnt(input bit pb, input string tag);
        bit got;
        got = 0;
        for (int i = 0; i < 6 && !got; i++) begin
            @(negedge clk);
            got = pb ? b_gnt : a_gnt;
        end
        chk(tag, got, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb, first;
        bit got;
        for (int i = 0; i < 64; i++) exp_mem[i] = init_val(i);
        nst = 0; a_req = 0; a_we = 0; a_lock = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
        repeat (3) @(negedge clk);
        chk_idle("reset_state");
        @(posedge clk); #1; nst = 1;
        @(posedge clk); #1;

        // Single read from A
        issue(0, 0, 6'd9, 2'b00, "rd9");
        @(negedge clk);
        chk("rd9_rvalid", a_rvalid, 1);
        chk("rd9_rdata", a_rdata, 2'b10);
        repeat (2) @(negedge clk);
        chk("rd9_hold", a_rdata, 2'b10);

        // Fresh reset, then both ports request continuously
        @(posedge clk); #1; nst = 0;
        @(negedge clk); chk_idle("reset_again");
        @(posedge clk); #1; nst = 1;
        @(posedge clk); #1;
        a_req = 1; a_we = 1; a_addr = 6'd1; a_wdata = 2'b11; exp_mem[1] = 2'b11;
        b_req = 1; b_we = 1; b_addr = 6'd2; b_wdata = 2'b01; exp_mem[2] = 2'b01;
        for (int k = 0; k < 9; k++) begin
            logic [1:0] e;
            @(negedge clk);
            e = (k == 0) ? 2'b00 : ((k % 2) == 1 ? 2'b10 : 2'b01);
            chk("alternate", {a_gnt, b_gnt}, e);
        end
        @(posedge clk); #1; a_req = 0; b_req = 0;
        repeat (2) @(posedge clk); #1;

        // Write then read the same cell from the other port
        issue(0, 1, 6'd20, 2'b11, "wr20");
        issue(1, 0, 6'd20, 2'b00, "rd20");
        drain("rd20");
        chk("rd20_bdata", b_rdata, 2'b11);

        // Lock without request must not block B
        a_lock = 1;
        issue(1, 0, 6'd9, 2'b00, "lock_noreq");
        a_lock = 0;
        drain("lock_noreq");

        // Short lock: B waits, then is served promptly
        a_req = 1; a_we = 0; a_addr = 6'd9; a_lock = 1; a_q.push_back(exp_mem[9]);
        b_req = 1; b_we = 0; b_addr = 6'd20; b_q.push_back(exp_mem[20]);
        wait_gnt(0, "short_lock_a_gnt");
        @(posedge clk); #1; a_req = 0;
        repeat (4) begin
            @(negedge clk);
            chk("short_lock_b_blocked", b_gnt, 0);
        end
        @(posedge clk); #1; a_lock = 0;
        got = 0;
        for (int i = 0; i < 2 && !got; i++) begin @(negedge clk); got = b_gnt; end
        chk("short_lock_b_after", got, 1);
        @(posedge clk); #1; b_req = 0;
        chk("short_lock_err", lock_err, 0);
        drain("short_lock");

        // Long lock: one forced B grant after LOCK_MAX blocked cycles
        a_req = 1; a_we = 0; a_addr = 6'd1; a_lock = 1; a_q.push_back(exp_mem[1]);
        b_req = 1; b_we = 0; b_addr = 6'd2; b_q.push_back(exp_mem[2]);
        wait_gnt(0, "long_lock_a_gnt");
        @(posedge clk); #1; a_req = 0;
        nb = 0; first = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (b_gnt) begin nb++; if (first == 0) first = i; end
            @(posedge clk); #1;
            if (nb > 0) b_req = 0;
        end
        a_lock = 0;
        chk("long_lock_b_count", nb, 1);
        chk("long_lock_b_first", first, 9);
        chk("long_lock_err", lock_err, 1);
        drain("long_lock");
        repeat (3) @(negedge clk);
        chk("long_lock_err_sticky", lock_err, 1);

        // Reset the cycle after a read grant
        @(posedge clk); #1;
        a_req = 1; a_we = 0; a_addr = 6'd9; a_q.push_back(exp_mem[9]);
        wait_gnt(0, "rst_mid_a_gnt");
        @(posedge clk); #1;
        nst = 0; a_req = 0;
        a_q.delete(); b_q.delete();
        @(negedge clk);
        chk_idle("rst_mid_idle");
        @(posedge clk); #1; nst = 1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_mid_no_rvalid", a_rvalid, 0);
        end
        @(posedge clk); #1;
        a_req = 1; a_we = 0; a_addr = 6'd9;  a_q.push_back(exp_mem[9]);
        b_req = 1; b_we = 0; b_addr = 6'd20; b_q.push_back(exp_mem[20]);
        got = 0;
        for (int i = 0; i < 4 && !got; i++) begin
            @(negedge clk);
            got = a_gnt | b_gnt;
        end
        chk("post_reset_tie", {a_gnt, b_gnt}, 2'b10);
        @(posedge clk); #1; a_req = 0;
        wait_gnt(1, "post_reset_b_gnt");
        @(posedge clk); #1; b_req = 0;
        drain("post_reset");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
